counter_bank: RTL and testbench

Multi-channel, parametrised up/down counter bank; successor to the single 8-bit wrap counter used in the test designs. Each channel has an independent direction, synchronous load, programmable terminal value, wrap-or-saturate mode, a terminal-count pulse and a sticky overflow flag. The block sits beside the simulation testbenches and timer-style peripherals as a drop-in event/interval counter array.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_channel.sv | 74 +++++++
 rtl/counter_bank.sv | 73 +++++++
 tb/tb_counter_bank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter bank.
// Channel mode, direction encodings and default parameter values.
package counter_pkg;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } mode_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 8;

endpackage

// File: rtl/counter_channel.sv
// One up/down counter channel with load, wrap/saturate,
// terminal-count pulse and sticky overflow flag.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             clear,
    input  logic             load,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf_sticky
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             sat_mode;

    assign sat_mode = (mode_e'(sat) == SAT);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (count_q >= limit) begin
                    tc_d    = 1'b1;
                    count_d = sat_mode ? limit : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = sat_mode ? '0 : limit;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
        // A terminal event on the same edge beats flag_clr.
        ovf_d = tc_d | (ovf_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: rtl/counter_bank.sv
// Array of independent up/down counters with optional shared
// prescaler, enabled by defining COUNTER_BANK_PRESCALE_EN.
module counter_bank
    import counter_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       clear,
    input  logic [NUM_CH-1:0]       dir,
    input  logic [NUM_CH-1:0]       sat,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH*WIDTH-1:0] limit,
    input  logic [NUM_CH-1:0]       flag_clr,
`ifdef COUNTER_BANK_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]   presc_div,
`endif
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       ovf_sticky
);

    logic tick;

`ifdef COUNTER_BANK_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q + PRESCALE_W'(1);
        tick    = 1'b0;
        if (presc_q == presc_div) begin
            presc_d = '0;
            tick    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = (PRESCALE_W > 0);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .step      (enable[i] & tick),
            .clear     (clear[i]),
            .load      (load[i]),
            .dir       (dir[i]),
            .sat       (sat[i]),
            .load_val  (load_val[i*WIDTH +: WIDTH]),
            .limit     (limit[i*WIDTH +: WIDTH]),
            .flag_clr  (flag_clr[i]),
            .count     (count[i*WIDTH +: WIDTH]),
            .tc        (tc[i]),
            .ovf_sticky(ovf_sticky[i])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: expected channel states are
// queued as stimulus is applied and compared after each clock edge.
module tb_counter_bank;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int PW  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NCH-1:0]  enable = '0, clear = '0, dir = '0, sat = '0;
    logic [NCH-1:0]  load = '0, flag_clr = '0;
    logic [NCH*W-1:0] load_val = '0, limit = '0;
    logic [PW-1:0]   presc_div = '0;
    logic [NCH*W-1:0] count;
    logic [NCH-1:0]  tc, ovf_sticky;

    typedef struct {
        int         ch;
        logic [W-1:0] cnt;
        logic       tc;
        logic       ovf;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    counter_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .dir       (dir),
        .sat       (sat),
        .load      (load),
        .load_val  (load_val),
        .limit     (limit),
        .flag_clr  (flag_clr),
`ifdef COUNTER_BANK_PRESCALE_EN
        .presc_div (presc_div),
`endif
        .count     (count),
        .tc        (tc),
        .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] obs(int ch);
        return {count[ch*W +: W], tc[ch], ovf_sticky[ch]};
    endfunction

    function automatic void push(int ch, int c, logic t, logic o, string nm);
        exp_t e;
        e.ch = ch; e.cnt = W'(c); e.tc = t; e.ovf = o; e.name = nm;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({count, tc, ovf_sticky} !== '0)
            $display("FAIL reset_state got count=%h tc=%b ovf=%b want 0",
                     count, tc, ovf_sticky);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_up_wrap();
        int seq[7] = '{1, 2, 3, 4, 5, 0, 1};
        exp_t e;
        @(negedge clk);
        limit[0*W +: W] = 8'd5;
        dir[0] = 1'b1; sat[0] = 1'b0; enable[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            push(0, seq[k], k == 5, k >= 5, $sformatf("up_wrap[%0d]", k));
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (obs(e.ch) !== {e.cnt, e.tc, e.ovf})
                    $display("FAIL %s got %h want %h", e.name, obs(e.ch),
                             {e.cnt, e.tc, e.ovf});
                else n_pass++;
            end
            @(negedge clk);
        end
        enable[0] = 1'b0;
    endtask

    task automatic test_down_sat();
        int seq[5] = '{2, 1, 0, 0, 0};
        exp_t e;
        limit[1*W +: W] = 8'd10;
        load_val[1*W +: W] = 8'd2;
        dir[1] = 1'b0; sat[1] = 1'b1; enable[1] = 1'b1; load[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push(1, seq[k], k >= 3, k >= 3, $sformatf("down_sat[%0d]", k));
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (obs(e.ch) !== {e.cnt, e.tc, e.ovf})
                    $display("FAIL %s got %h want %h", e.name, obs(e.ch),
                             {e.cnt, e.tc, e.ovf});
                else n_pass++;
            end
            @(negedge clk);
            load[1] = 1'b0;
        end
        enable[1] = 1'b0;
    endtask

    task automatic test_load_over_limit();
        exp_t e;
        limit[2*W +: W] = 8'd100;
        load_val[2*W +: W] = 8'd200;
        dir[2] = 1'b1; sat[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            load[2]   = (k == 0 || k == 2);
            enable[2] = (k == 1 || k == 3);
            clear[2]  = (k == 3);
            case (k)
                0: push(2, 200, 1'b0, 1'b0, "load_200");
                1: push(2, 0, 1'b1, 1'b1, "over_limit_wrap");
                2: push(2, 200, 1'b0, 1'b1, "reload_200");
                default: push(2, 0, 1'b0, 1'b1, "clear_beats_step");
            endcase
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (obs(e.ch) !== {e.cnt, e.tc, e.ovf})
                    $display("FAIL %s got %h want %h", e.name, obs(e.ch),
                             {e.cnt, e.tc, e.ovf});
                else n_pass++;
            end
            @(negedge clk);
        end
        {load[2], enable[2], clear[2]} = '0;
    endtask

    task automatic test_flag_clr();
        exp_t e;
        limit[3*W +: W] = 8'd1;
        dir[3] = 1'b1; sat[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            enable[3]   = (k < 2);
            flag_clr[3] = (k >= 1);
            case (k)
                0: push(3, 1, 1'b0, 1'b0, "flag_pre");
                1: push(3, 0, 1'b1, 1'b1, "flag_clr_vs_tc");
                default: push(3, 0, 1'b0, 1'b0, "flag_clr_alone");
            endcase
            @(posedge clk); #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total++;
                if (obs(e.ch) !== {e.cnt, e.tc, e.ovf})
                    $display("FAIL %s got %h want %h", e.name, obs(e.ch),
                             {e.cnt, e.tc, e.ovf});
                else n_pass++;
            end
            @(negedge clk);
        end
        {enable[3], flag_clr[3]} = '0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0; enable[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push(0, 3, 1'b0, 1'b1, "pre_reset_count");
        e = sb.pop_front();
        n_total++;
        if (obs(e.ch) !== {e.cnt, e.tc, e.ovf})
            $display("FAIL %s got %h want %h", e.name, obs(e.ch),
                     {e.cnt, e.tc, e.ovf});
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({count, tc, ovf_sticky} !== '0)
            $display("FAIL async_reset got count=%h tc=%b ovf=%b want 0",
                     count, tc, ovf_sticky);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 1, 1'b0, 1'b0, "first_step_after_reset");
        @(posedge clk); #1;
        e = sb.pop_front();
        n_total++;
        if (obs(e.ch) !== {e.cnt, e.tc, e.ovf})
            $display("FAIL %s got %h want %h", e.name, obs(e.ch),
                     {e.cnt, e.tc, e.ovf});
        else n_pass++;
        @(negedge clk);
        enable[0] = 1'b0;
    endtask

    task automatic test_prescale();
        exp_t e;
        logic [W-1:0] start;
        limit[0*W +: W] = 8'd200;
        dir[0] = 1'b1; sat[0] = 1'b0;
`ifdef COUNTER_BANK_PRESCALE_EN
        presc_div = 8'd3;
        @(negedge clk);
        start = count[0 +: W];
        enable[0] = 1'b1;
        push(0, int'(start) + 4, 1'b0, 1'b0, "presc_div3_16cyc");
        repeat (16) @(negedge clk);
`else
        @(negedge clk);
        start = count[0 +: W];
        enable[0] = 1'b1;
        push(0, int'(start) + 16, 1'b0, 1'b0, "no_presc_16cyc");
        repeat (16) @(negedge clk);
`endif
        e = sb.pop_front();
        n_total++;
        if (obs(e.ch) !== {e.cnt, e.tc, e.ovf})
            $display("FAIL %s got %h want %h", e.name, obs(e.ch),
                     {e.cnt, e.tc, e.ovf});
        else n_pass++;
        presc_div = 8'd0;
        start = count[0 +: W];
        push(0, int'(start) + 4, 1'b0, 1'b0, "presc_div0_4cyc");
        repeat (4) @(negedge clk);
        e = sb.pop_front();
        n_total++;
        if (obs(e.ch) !== {e.cnt, e.tc, e.ovf})
            $display("FAIL %s got %h want %h", e.name, obs(e.ch),
                     {e.cnt, e.tc, e.ovf});
        else n_pass++;
        enable[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_load_over_limit();
        test_flag_clr();
        test_async_reset();
        test_prescale();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
